// File: rtl/exp3_exerciser.sv
// rtl/exp3_exerciser.sv - stimulus/response exerciser for the 3-input lab logic cell
//
// Steps through all eight {a,b,c} input vectors of the cell under test, waits
// SETTLE_CYCLES clocks after applying each one, then compares the cell's x/y
// against a built-in golden model. Reports pass, error count and first failing
// vector at the end of the run.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - begin a run (only looked at while idle)
//   a_o/b_o/c_o- stimulus to the cell, a = vec[2], b = vec[1], c = vec[0]
//   x_i/y_i    - cell responses, synchronous to clk
//   busy       - run in progress
//   done       - one-cycle pulse when a run finishes
//   pass       - last run had no mismatches (held)
//   err_cnt    - mismatching vectors in last run, 0..8 (held)
//   fail_valid - at least one mismatch in last run (held)
//   fail_vec   - index of first mismatching vector (held)

module exp3_exerciser #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       x_i,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    // Counter is kept at least one bit wide so SETTLE_CYCLES of 0 or 1 still elaborates.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic             a_q;
    logic             b_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [3:0]       err_cnt_q;
    logic             fail_valid_q;
    logic [2:0]       fail_vec_q;

    logic             ab_or;
    logic             ab_and;
    logic             x_exp;
    logic             y_exp;
    logic             mismatch;
    logic [3:0]       err_cnt_d;
    logic [2:0]       vec_d;

    // Golden model of the cell for the vector currently being checked.
    assign ab_or     = vec_q[2] | vec_q[1];
    assign ab_and    = vec_q[2] & vec_q[1];
    assign x_exp     = ~vec_q[0] ^ ab_or;
    assign y_exp     = ab_or & (~ab_and ^ ab_or);
    assign mismatch  = (x_i != x_exp) || (y_i != y_exp);
    assign err_cnt_d = err_cnt_q + {3'b000, mismatch};
    assign vec_d     = vec_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= 3'd0;
            cnt_q        <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            c_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= 4'd0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_DRIVE;
                        busy_q       <= 1'b1;
                        vec_q        <= 3'd0;
                        cnt_q        <= '0;
                        {a_q, b_q, c_q} <= 3'd0;
                        err_cnt_q    <= 4'd0;
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= 3'd0;
                        pass_q       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    cnt_q <= '0;
                    if (SETTLE_CYCLES > 0) begin
                        state_q <= S_SETTLE;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_cnt_q <= err_cnt_d;
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_vec_q   <= vec_q;
                        end
                    end
                    if (vec_q == 3'd7) begin
                        // Stimulus is left at vector 7 until the next start.
                        state_q <= S_DONE;
                    end else begin
                        vec_q           <= vec_d;
                        {a_q, b_q, c_q} <= vec_d;
                        state_q         <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_q == 4'd0);
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_o        = a_q;
    assign b_o        = b_q;
    assign c_o        = c_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule
